// File: rtl/canny_frame_ctrl.sv
// Frame sequencer for the Canny back end (NMS -> threshold/edge-link -> AXI out).
// Gates the pipeline enable, latches per-frame thresholds, counts pixels, flushes.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             1-cycle pulse, begins a frame (IDLE only)
//   abort             level, terminates the current frame
//   cfg_gth, cfg_gtl  thresholds, sampled on an accepted start
//   s_valid, s_ready  input pixel handshake
//   m_ready           downstream sink ready
//   pipe_en           enable to threshold stage / line buffers
//   gth, gtl          thresholds latched for the current frame
//   sof, eol          registered pulses: first pixel of frame / last pixel of line
//   busy              controller not idle
//   frame_done        pulse at the end of the flush phase
//   cfg_err           sticky: start rejected because cfg_gtl > cfg_gth
//   row_idx           current input row

module canny_frame_ctrl #(
    parameter int IMG_W     = 1024,
    parameter int IMG_H     = 768,
    parameter int FLUSH_CYC = IMG_W + 4,
    parameter int CW        = $clog2(IMG_W),
    parameter int RW        = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [7:0]    cfg_gth,
    input  logic [7:0]    cfg_gtl,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic          m_ready,
    output logic          pipe_en,
    output logic [7:0]    gth,
    output logic [7:0]    gtl,
    output logic          sof,
    output logic          eol,
    output logic          busy,
    output logic          frame_done,
    output logic          cfg_err,
    output logic [RW-1:0] row_idx
);

    localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [FW-1:0] flush_q, flush_d;
    logic [7:0]    gth_q, gth_d;
    logic [7:0]    gtl_q, gtl_d;
    logic          cfg_err_q, cfg_err_d;
    logic          sof_q, sof_d;
    logic          eol_q, eol_d;

    logic cfg_ok;
    logic accept;
    logic last_col;
    logic last_row;
    logic flush_last;

    assign cfg_ok     = (cfg_gtl <= cfg_gth);
    assign accept     = s_valid && s_ready;
    assign last_col   = (col_q == CW'(IMG_W - 1));
    assign last_row   = (row_q == RW'(IMG_H - 1));
    assign flush_last = (flush_q == FW'(FLUSH_CYC - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort outranks every other transition
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start && !abort && cfg_ok) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (accept && last_col && last_row) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (pipe_en && flush_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic. Enables are qualified by m_ready so nothing moves
    // without a sink, and by abort so a dying frame issues no enable.
    always_comb begin
        s_ready    = 1'b0;
        pipe_en    = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            IDLE: begin
            end
            RUN: begin
                s_ready = m_ready && !abort;
                pipe_en = s_valid && m_ready && !abort;
            end
            FLUSH: begin
                pipe_en = m_ready && !abort;
            end
            DONE: begin
                frame_done = !abort;
            end
            default: begin
            end
        endcase
    end

    assign busy = (state_q != IDLE);

    // Counters, thresholds and pulse generation
    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        flush_d   = flush_q;
        gth_d     = gth_q;
        gtl_d     = gtl_q;
        cfg_err_d = cfg_err_q;
        sof_d     = 1'b0;
        eol_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    if (cfg_ok) begin
                        gth_d     = cfg_gth;
                        gtl_d     = cfg_gtl;
                        cfg_err_d = 1'b0;
                        col_d     = '0;
                        row_d     = '0;
                        flush_d   = '0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    col_d   = '0;
                    row_d   = '0;
                    flush_d = '0;
                end else if (accept) begin
                    sof_d = (col_q == '0) && (row_q == '0);
                    if (last_col) begin
                        col_d   = '0;
                        eol_d   = 1'b1;
                        flush_d = '0;
                        // Row wraps to 0 after the final line; flush follows
                        row_d   = last_row ? '0 : row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (abort) begin
                    col_d   = '0;
                    row_d   = '0;
                    flush_d = '0;
                end else if (pipe_en) begin
                    flush_d = flush_q + 1'b1;
                end
            end
            DONE: begin
                col_d   = '0;
                row_d   = '0;
                flush_d = '0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q     <= '0;
            row_q     <= '0;
            flush_q   <= '0;
            gth_q     <= '0;
            gtl_q     <= '0;
            cfg_err_q <= 1'b0;
            sof_q     <= 1'b0;
            eol_q     <= 1'b0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            flush_q   <= flush_d;
            gth_q     <= gth_d;
            gtl_q     <= gtl_d;
            cfg_err_q <= cfg_err_d;
            sof_q     <= sof_d;
            eol_q     <= eol_d;
        end
    end

    assign gth     = gth_q;
    assign gtl     = gtl_q;
    assign cfg_err = cfg_err_q;
    assign sof     = sof_q;
    assign eol     = eol_q;
    assign row_idx = row_q;

endmodule
